shift_add_mult: RTL
===================

Name: shift_add_mult

Overview:
Sequential unsigned shift-and-add multiplier. It is the consumer stage of the team's ripple-carry adder: each cycle it presents the accumulator and multiplicand to a WIDTH-bit adder and takes back the sum and carry-out. It produces a 2*WIDTH-bit product after WIDTH iteration cycles, using a start/busy/done handshake toward the controlling logic.

Parameters:
WIDTH, 4, operand width in bits; product is 2*WIDTH bits; minimum value 2.

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE or DONE
a  input  WIDTH  multiplicand; captured when start is accepted
b  input  WIDTH  multiplier; captured when start is accepted
busy  output  1  high while an operation is in progress (RUN state)
done  output  1  one-cycle pulse; p is valid from this cycle onward
p  output  2*WIDTH  product register; holds its value until the next done

Behaviour:
- Reset: state=IDLE; busy=0, done=0, p=0; internal mcand, acc, q and count are cleared. rst has priority over all other inputs in every state, including mid-RUN: the operation is abandoned and no done is produced.
- Internal registers:
  - mcand [WIDTH]
  - acc [WIDTH], upper half of the working product
  - q [WIDTH], multiplier, which becomes the lower half
  - count, counting down from WIDTH
- State IDLE:
  - start=1 → mcand=a, q=b, acc=0, count=WIDTH; go to RUN.
  - start=0 → stay in IDLE.
- State RUN (busy=1):
  - Adder input is acc + (q[0] ? mcand : 0), giving a WIDTH-bit sum plus carry-out c.
  - {c, sum, q} shifts right by one: acc takes {c, sum[WIDTH-1:1]}, and q takes {sum[0], q[WIDTH-1:1]}.
  - count decrements by 1.
  - When count==1 on this edge, go to DONE and load p from the final {acc, q} at the same edge.
- State DONE (done=1, busy=0), lasting one cycle:
  - start=1 → accepted exactly as in IDLE; go to RUN. This gives back-to-back operation.
  - start=0 → go to IDLE.
- Latency: start is sampled at edge k, and done is high in the cycle following edge k+WIDTH. Total is WIDTH+1 edges, which is 5 for WIDTH=4.
- Throughput: one result every WIDTH+1 cycles with start held high.
- start asserted in RUN is ignored. a and b may change freely after acceptance without affecting the result.
- p changes only at the edge that enters DONE, or on rst. p is stable between those events.
- Arithmetic is unsigned. The carry-out is never lost: the product of the maximum operands, (2^WIDTH-1)^2, fits in 2*WIDTH bits.
- busy and done are registered outputs derived from state. They are never high simultaneously.

Optional Feature:
Macro: MULT_ZERO_SKIP_EN
- Defined: when start is accepted with a==0 or b==0, the block skips RUN and goes directly to DONE on the next edge with p=0. Latency is 1 edge and busy is never asserted. Nonzero operands behave exactly as in the base behaviour.
- Undefined: zero operands take the full WIDTH+1 latency like any other operands, producing p=0.

Test Plan (WIDTH=4):
1. rst=1 for 2 cycles, then release → busy=0, done=0, p=0x00; no activity without start.
2. start with a=15, b=15 at edge k → busy high for edges k+1..k+4; done pulses once in the cycle after edge k+4; p=0xE1 (225) and it holds afterwards.
3. a=7, b=9 accepted, then a=3, b=3 applied and start=1 pulsed while busy → the second start is ignored; p=0x3F (63) with exactly one done pulse.
4. start held high, first a=13, b=11, then a=2, b=6 presented during the DONE cycle → p=0x8F (143), then p=0x0C (12), with done pulses 5 cycles apart.
5. a=0, b=9 → p=0x00. Without MULT_ZERO_SKIP_EN, done comes after 5 edges. With the macro, done comes after 1 edge and busy stays 0.
6. a=12, b=10 accepted, then rst=1 asserted at the 2nd RUN edge → state IDLE, busy=0, done never pulses, p=0x00. A subsequent a=12, b=10 run gives p=0x78 (120).

Source files
------------

// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier: WIDTH iterations, start/busy/done handshake.
// Optional MULT_ZERO_SKIP_EN: a zero operand finishes in one edge and never enters RUN.
module shift_add_mult #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p,
  output logic [1:0]         dbg_state
);

  // Handshake: start is sampled only in IDLE or DONE; busy is high for the
  // whole RUN phase; done is a one-cycle pulse and p is valid from that cycle
  // until the next done. busy and done are decoded from the state register.

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] p_q, p_d;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum_full;

  // Adder stage: carry-out lands in sum_full[WIDTH] and is shifted into acc.
  assign addend   = q_q[0] ? mcand_q : '0;
  assign sum_full = {1'b0, acc_q} + {1'b0, addend};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      count_q <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      count_q <= count_d;
      p_q     <= p_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    q_d     = q_q;
    count_d = count_q;
    p_d     = p_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mcand_d = a;
          q_d     = b;
          acc_d   = '0;
          count_d = CW'(WIDTH);
          state_d = S_RUN;
`ifdef MULT_ZERO_SKIP_EN
          if ((a == '0) || (b == '0)) begin
            state_d = S_DONE;
            p_d     = '0;
          end
`endif
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d   = sum_full[WIDTH:1];
        q_d     = {sum_full[0], q_q[WIDTH-1:1]};
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = S_DONE;
          p_d     = {sum_full[WIDTH:1], sum_full[0], q_q[WIDTH-1:1]};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign p         = p_q;
  assign dbg_state = state_q;

endmodule
